abacus_cache_profiler: RTL and testbench
========================================

Name: abacus_cache_profiler

Overview:
- Cache-event conditioning and counting stage inside abacus_top, directly downstream of the core's cache nets.
- Converts level-type core signals into event counts: request/miss/hit rising edges, and line-fill latency in cycles.
- Exposes results through an indexed read port consumed by the abacus_top Wishbone read mux.
- Enable comes from the cache-profiler control register at offset 0x8.

Parameters:
COUNTER_WIDTH, 32, width of every counter and of rd_data.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
enable  input  1  cache profiler enable (control reg bit 0)
abacus_icache_request  input  1  icache request level from core
abacus_icache_miss  input  1  icache miss level
abacus_icache_line_fill_in_progress  input  1  icache fill busy level
abacus_dcache_request  input  1  dcache request level
abacus_dcache_hit  input  1  dcache hit level
abacus_dcache_line_fill_in_progress  input  1  dcache fill busy level
rd_sel  input  4  register index (see package enum)
rd_data  output  COUNTER_WIDTH  selected register, registered
overflow  output  1  OR of all sticky saturation flags

Behaviour:
- Reset (rst=0, async): all counters, edge-history registers, trackers, sticky flags, rd_data and overflow go to 0.
- Edge history registers sample all six inputs every cycle, regardless of enable. An event is prev=0 and cur=1.
  - A level already high when enable rises is not counted.
- Index map:
  - 0 ICACHE_REQ: icache request rising edges.
  - 1 ICACHE_MISS: icache miss rising edges.
  - 2 ICACHE_FILL_CYC: cycles with icache fill high.
  - 3 ICACHE_FILL_MAX: longest single icache fill.
  - 4 DCACHE_REQ: dcache request rising edges.
  - 5 DCACHE_HIT: dcache hit rising edges.
  - 6 DCACHE_FILL_CYC: cycles with dcache fill high.
  - 7 DCACHE_FILL_MAX: longest single dcache fill.
  - 8 STATUS: bits[7:0] are the sticky saturation flags per index 0-7; remaining bits 0.
  - 9-15: read 0.
- Counting happens only while enable=1. When enable=0, all counters, trackers and sticky flags are held at 0 (synchronous clear). Disabling therefore clears all results.
- Simultaneous enable 1->0 and an event in the same cycle: clear wins.
- Saturation: a counter at all-ones stays at all-ones and sets its sticky flag. The flag clears only on disable or reset.
- Fill tracker FSM (one per cache):
  - IDLE: fill=1 and enable → FILL with cur_len=1.
  - FILL: fill=1 → cur_len+1, saturating. fill=0 → if cur_len>max then max<=cur_len; return to IDLE.
  - enable=0 in any state → IDLE, cur_len=0, max=0.
  - enable rising mid-fill: tracker enters FILL on that cycle; the partial length counts.
  - Max update and the CYC counter are independent. The fill-ending cycle adds nothing to CYC.
- rd_data = register[rd_sel], registered: 1-cycle latency, value as of the previous edge.
- overflow is combinational OR of the sticky flags.

Optional Feature:
ABACUS_CACHE_FILL_MAX_EN
- Defined: both max trackers are built; indices 3 and 7 return the tracked maximum.
- Undefined: trackers are not instantiated; indices 3/7 read 0 and their sticky flags are tied to 0. The CYC counters remain.

Decomposition:
- abacus_pkg holds:
  - the abacus_cache_reg_e enum (indices 0-9);
  - ABACUS_CACHE_PROF_CTRL_OFFSET = 32'h8;
  - the default COUNTER_WIDTH constant.
- Sub-module abacus_fill_tracker contains the IDLE/FILL FSM, cur_len and max. It is instantiated twice (icache, dcache) under ABACUS_CACHE_FILL_MAX_EN.

Test Plan:
1. Reset, enable=1, icache_request held high 5 cycles then low → ICACHE_REQ=1, ICACHE_MISS=0.
2. icache_miss and icache fill high for 5 cycles, then both low → ICACHE_MISS=1, ICACHE_FILL_CYC=5, ICACHE_FILL_MAX=5 (0 without macro).
3. dcache fills of 3, 7, 2 cycles separated by idle gaps → DCACHE_FILL_CYC=12, DCACHE_FILL_MAX=7. dcache_hit toggled 4 times → DCACHE_HIT=4.
4. After scenario 3, drive enable=0 for one cycle → every index reads 0 one cycle after rd_sel is applied; overflow=0.
5. COUNTER_WIDTH=4, dcache_request pulsed 20 times → DCACHE_REQ=4'hF, STATUS bit4=1, overflow=1. Disable → STATUS=0.
6. Assert rst low mid-fill with counters nonzero → immediate zero of rd_data and overflow. Release with fill still high and enable=1 → the fill is not counted as a new event edge; FILL_CYC increments from the first enabled cycle.

Source files
------------

// File: rtl/abacus_pkg.sv
// Shared types and constants for the abacus cache profiler: read-port register map,
// fill-tracker FSM states and default counter width.
package abacus_pkg;

    localparam int          ABACUS_COUNTER_WIDTH          = 32;
    localparam logic [31:0] ABACUS_CACHE_PROF_CTRL_OFFSET = 32'h8;

    typedef enum logic [3:0] {
        ABACUS_CACHE_ICACHE_REQ      = 4'd0,
        ABACUS_CACHE_ICACHE_MISS     = 4'd1,
        ABACUS_CACHE_ICACHE_FILL_CYC = 4'd2,
        ABACUS_CACHE_ICACHE_FILL_MAX = 4'd3,
        ABACUS_CACHE_DCACHE_REQ      = 4'd4,
        ABACUS_CACHE_DCACHE_HIT      = 4'd5,
        ABACUS_CACHE_DCACHE_FILL_CYC = 4'd6,
        ABACUS_CACHE_DCACHE_FILL_MAX = 4'd7,
        ABACUS_CACHE_STATUS          = 4'd8,
        ABACUS_CACHE_RSVD_FIRST      = 4'd9
    } abacus_cache_reg_e;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_BUSY = 1'b1
    } fill_state_e;

endpackage

// File: rtl/abacus_cache_profiler_if.sv
// Core-side cache level nets seen by the profiler, plus the fill-tracker states
// the profiler exposes back for observation.
interface abacus_cache_profiler_if;
    import abacus_pkg::*;

    logic        abacus_icache_request;
    logic        abacus_icache_miss;
    logic        abacus_icache_line_fill_in_progress;
    logic        abacus_dcache_request;
    logic        abacus_dcache_hit;
    logic        abacus_dcache_line_fill_in_progress;
    fill_state_e icache_fill_state;
    fill_state_e dcache_fill_state;

    // Levels only: no handshake, the profiler samples every cycle and never stalls the core.
    modport core (
        output abacus_icache_request, abacus_icache_miss, abacus_icache_line_fill_in_progress,
        output abacus_dcache_request, abacus_dcache_hit, abacus_dcache_line_fill_in_progress,
        input  icache_fill_state, dcache_fill_state
    );

    modport profiler (
        input  abacus_icache_request, abacus_icache_miss, abacus_icache_line_fill_in_progress,
        input  abacus_dcache_request, abacus_dcache_hit, abacus_dcache_line_fill_in_progress,
        output icache_fill_state, dcache_fill_state
    );

endinterface

// File: rtl/abacus_fill_tracker.sv
// Line-fill length tracker: measures each fill and keeps the longest one seen since
// enable rose. sat flags a fill that ran past all-ones (max then settles at all-ones).
module abacus_fill_tracker
    import abacus_pkg::*;
#(
    parameter int WIDTH = ABACUS_COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fill,
    output logic [WIDTH-1:0] max_len,
    output logic             sat,
    output fill_state_e      state
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    fill_state_e      state_n;
    logic [WIDTH-1:0] cur_len, cur_len_n, max_len_n;
    logic             sat_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FILL_IDLE;
            cur_len <= '0;
            max_len <= '0;
            sat     <= 1'b0;
        end else begin
            state   <= state_n;
            cur_len <= cur_len_n;
            max_len <= max_len_n;
            sat     <= sat_n;
        end
    end

    always_comb begin
        state_n   = state;
        cur_len_n = cur_len;
        max_len_n = max_len;
        sat_n     = sat;
        if (!enable) begin
            state_n   = FILL_IDLE;
            cur_len_n = '0;
            max_len_n = '0;
            sat_n     = 1'b0;
        end else begin
            case (state)
                FILL_IDLE: begin
                    // A fill already running when enable rises starts here too, so its tail counts.
                    if (fill) begin
                        state_n   = FILL_BUSY;
                        cur_len_n = WIDTH'(1);
                    end
                end
                FILL_BUSY: begin
                    if (fill) begin
                        if (cur_len == ALL_ONES) sat_n = 1'b1;
                        else                     cur_len_n = cur_len + WIDTH'(1);
                    end else begin
                        if (cur_len > max_len) max_len_n = cur_len;
                        state_n = FILL_IDLE;
                    end
                end
                default: state_n = FILL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/abacus_cache_profiler.sv
// Cache-event profiler: edge-detects core cache levels, counts events and fill cycles
// while enabled, and serves results through a registered indexed read port.
// Optional build macro ABACUS_CACHE_FILL_MAX_EN adds per-cache longest-fill trackers.
module abacus_cache_profiler
    import abacus_pkg::*;
#(
    parameter int COUNTER_WIDTH = ABACUS_COUNTER_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    abacus_cache_profiler_if.profiler cache,
    input  logic [3:0]                rd_sel,
    output logic [COUNTER_WIDTH-1:0]  rd_data,
    output logic                      overflow
);

    localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = '1;

    logic [5:0] level, level_q, rise, inc;

    assign level = {cache.abacus_dcache_line_fill_in_progress, cache.abacus_dcache_hit,
                    cache.abacus_dcache_request, cache.abacus_icache_line_fill_in_progress,
                    cache.abacus_icache_miss, cache.abacus_icache_request};
    assign rise  = level & ~level_q;
    // Counter slots: 0 ireq, 1 imiss, 2 ifill cycles, 3 dreq, 4 dhit, 5 dfill cycles.
    assign inc   = {level[5], rise[4], rise[3], level[2], rise[1], rise[0]};

    logic [COUNTER_WIDTH-1:0] cnt [6];
    logic [5:0]               cnt_sat;
    logic [COUNTER_WIDTH-1:0] imax, dmax;
    logic                     imax_sat, dmax_sat;
    logic [7:0]               sticky;
    logic [COUNTER_WIDTH-1:0] rd_next;

    // History runs regardless of enable, so a level already high at enable is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) level_q <= '0;
        else      level_q <= level;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
            cnt_sat <= '0;
        end else if (!enable) begin
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
            cnt_sat <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (inc[i]) begin
                    if (cnt[i] == ALL_ONES) cnt_sat[i] <= 1'b1;
                    else                    cnt[i]     <= cnt[i] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

`ifdef ABACUS_CACHE_FILL_MAX_EN
    abacus_fill_tracker #(.WIDTH(COUNTER_WIDTH)) u_icache_fill (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .fill    (level[2]),
        .max_len (imax),
        .sat     (imax_sat),
        .state   (cache.icache_fill_state)
    );

    abacus_fill_tracker #(.WIDTH(COUNTER_WIDTH)) u_dcache_fill (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .fill    (level[5]),
        .max_len (dmax),
        .sat     (dmax_sat),
        .state   (cache.dcache_fill_state)
    );
`else
    assign imax                    = '0;
    assign dmax                    = '0;
    assign imax_sat                = 1'b0;
    assign dmax_sat                = 1'b0;
    assign cache.icache_fill_state = FILL_IDLE;
    assign cache.dcache_fill_state = FILL_IDLE;
`endif

    assign sticky   = {dmax_sat, cnt_sat[5:3], imax_sat, cnt_sat[2:0]};
    assign overflow = |sticky;

    // Narrow builds only show the low STATUS flags; overflow still covers all eight.
    always_comb begin
        rd_next = '0;
        case (rd_sel)
            ABACUS_CACHE_ICACHE_REQ:      rd_next = cnt[0];
            ABACUS_CACHE_ICACHE_MISS:     rd_next = cnt[1];
            ABACUS_CACHE_ICACHE_FILL_CYC: rd_next = cnt[2];
            ABACUS_CACHE_ICACHE_FILL_MAX: rd_next = imax;
            ABACUS_CACHE_DCACHE_REQ:      rd_next = cnt[3];
            ABACUS_CACHE_DCACHE_HIT:      rd_next = cnt[4];
            ABACUS_CACHE_DCACHE_FILL_CYC: rd_next = cnt[5];
            ABACUS_CACHE_DCACHE_FILL_MAX: rd_next = dmax;
            ABACUS_CACHE_STATUS:          rd_next = COUNTER_WIDTH'(sticky);
            default:                      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= rd_next;
    end

endmodule

// File: tb/tb_abacus_cache_profiler.sv
// Bench for abacus_cache_profiler: a 32-bit and a 4-bit instance share stimulus and
// are checked each cycle against an unbounded-count reference model.
module tb_abacus_cache_profiler;
    import abacus_pkg::*;

`ifdef ABACUS_CACHE_FILL_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif
    localparam longint unsigned MAX32 = 64'hFFFF_FFFF;
    localparam longint unsigned MAX4  = 64'd15;

    logic        clk, rst, en;
    logic [3:0]  rd_sel;
    logic [31:0] rd_data;
    logic [3:0]  rd_data_n;
    logic        overflow, overflow_n;
    logic [5:0]  lv;  // ireq, imiss, ifill, dreq, dhit, dfill

    abacus_cache_profiler_if cif ();
    abacus_cache_profiler_if cif_n ();

    abacus_cache_profiler #(.COUNTER_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .enable(en), .cache(cif),
        .rd_sel(rd_sel), .rd_data(rd_data), .overflow(overflow)
    );

    abacus_cache_profiler #(.COUNTER_WIDTH(4)) dut_n (
        .clk(clk), .rst(rst), .enable(en), .cache(cif_n),
        .rd_sel(rd_sel), .rd_data(rd_data_n), .overflow(overflow_n)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: true (unbounded) counts, clamped only when viewed
    longint unsigned n [6];
    longint unsigned run [2], mx [2], peak [2];
    logic [5:0]      prev;
    logic [31:0]     exp_q [$];
    logic [31:0]     exp_n_q [$];
    int              checks, errors;

    task automatic model_clear();
        for (int i = 0; i < 6; i++) n[i] = 0;
        for (int c = 0; c < 2; c++) begin
            run[c] = 0; mx[c] = 0; peak[c] = 0;
        end
    endtask

    task automatic model_step();
        if (!en) begin
            model_clear();
        end else begin
            if (lv[0] && !prev[0]) n[0]++;
            if (lv[1] && !prev[1]) n[1]++;
            if (lv[2])             n[2]++;
            if (lv[3] && !prev[3]) n[3]++;
            if (lv[4] && !prev[4]) n[4]++;
            if (lv[5])             n[5]++;
            for (int c = 0; c < 2; c++) begin
                if (c == 0 ? lv[2] : lv[5]) begin
                    run[c]++;
                    if (run[c] > peak[c]) peak[c] = run[c];
                end else begin
                    if (run[c] > mx[c]) mx[c] = run[c];
                    run[c] = 0;
                end
            end
        end
        prev = lv;
    endtask

    function automatic logic [31:0] clamp(input longint unsigned x, input longint unsigned m);
        return (x > m) ? m[31:0] : x[31:0];
    endfunction

    function automatic logic [7:0] flags(input longint unsigned m);
        logic [7:0] f;
        f    = '0;
        f[0] = n[0] > m;
        f[1] = n[1] > m;
        f[2] = n[2] > m;
        f[4] = n[3] > m;
        f[5] = n[4] > m;
        f[6] = n[5] > m;
        if (MAX_EN) begin
            f[3] = peak[0] > m;
            f[7] = peak[1] > m;
        end
        return f;
    endfunction

    function automatic logic [31:0] view(input logic [3:0] sel, input longint unsigned m);
        case (sel)
            4'd0: return clamp(n[0], m);
            4'd1: return clamp(n[1], m);
            4'd2: return clamp(n[2], m);
            4'd3: return MAX_EN ? clamp(mx[0], m) : 32'd0;
            4'd4: return clamp(n[3], m);
            4'd5: return clamp(n[4], m);
            4'd6: return clamp(n[5], m);
            4'd7: return MAX_EN ? clamp(mx[1], m) : 32'd0;
            4'd8: return {24'd0, flags(m)} & m[31:0];
            default: return 32'd0;
        endcase
    endfunction

    // checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver
    task automatic drive();
        cif.abacus_icache_request                 = lv[0];
        cif.abacus_icache_miss                    = lv[1];
        cif.abacus_icache_line_fill_in_progress   = lv[2];
        cif.abacus_dcache_request                 = lv[3];
        cif.abacus_dcache_hit                     = lv[4];
        cif.abacus_dcache_line_fill_in_progress   = lv[5];
        cif_n.abacus_icache_request               = lv[0];
        cif_n.abacus_icache_miss                  = lv[1];
        cif_n.abacus_icache_line_fill_in_progress = lv[2];
        cif_n.abacus_dcache_request               = lv[3];
        cif_n.abacus_dcache_hit                   = lv[4];
        cif_n.abacus_dcache_line_fill_in_progress = lv[5];
    endtask

    // one clock: scoreboard the registered read port and overflow of both instances
    task automatic tick();
        drive();
        @(posedge clk);
        if (!rst) begin
            exp_q.push_back(32'd0);
            exp_n_q.push_back(32'd0);
            model_clear();
            prev = '0;
        end else begin
            exp_q.push_back(view(rd_sel, MAX32));
            exp_n_q.push_back(view(rd_sel, MAX4));
            model_step();
        end
        #1;
        chk("rd_data", rd_data, exp_q.pop_front());
        chk("rd_data_n", {28'd0, rd_data_n}, exp_n_q.pop_front());
        chk("overflow", {31'd0, overflow}, {31'd0, |flags(MAX32)});
        chk("overflow_n", {31'd0, overflow_n}, {31'd0, |flags(MAX4)});
    endtask

    task automatic cyc(input logic [5:0] v, input int count);
        lv = v;
        repeat (count) tick();
    endtask

    task automatic rd_check(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        rd_sel = sel;
        tick();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b0;
        rd_sel = 4'd0;
        lv     = '0;
        prev   = '0;
        model_clear();
        drive();
        #2 rst = 1'b0;
        #1;
        chk("reset_rd", rd_data, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        en  = 1'b1;

        // 1: request held high 5 cycles is one event
        cyc(6'b000001, 5);
        cyc(6'b000000, 1);
        rd_check("ireq_one", ABACUS_CACHE_ICACHE_REQ, 32'd1);
        rd_check("imiss_zero", ABACUS_CACHE_ICACHE_MISS, 32'd0);

        // 2: miss plus 5-cycle icache fill
        cyc(6'b000110, 5);
        cyc(6'b000000, 1);
        rd_check("imiss_one", ABACUS_CACHE_ICACHE_MISS, 32'd1);
        rd_check("icyc_5", ABACUS_CACHE_ICACHE_FILL_CYC, 32'd5);
        rd_check("imax_5", ABACUS_CACHE_ICACHE_FILL_MAX, MAX_EN ? 32'd5 : 32'd0);

        // 3: dcache fills of 3, 7, 2 cycles and four hit pulses
        cyc(6'b100000, 3); cyc(6'b000000, 2);
        cyc(6'b100000, 7); cyc(6'b000000, 2);
        cyc(6'b100000, 2); cyc(6'b000000, 2);
        repeat (4) begin
            cyc(6'b010000, 1);
            cyc(6'b000000, 1);
        end
        rd_check("dcyc_12", ABACUS_CACHE_DCACHE_FILL_CYC, 32'd12);
        rd_check("dmax_7", ABACUS_CACHE_DCACHE_FILL_MAX, MAX_EN ? 32'd7 : 32'd0);
        rd_check("dhit_4", ABACUS_CACHE_DCACHE_HIT, 32'd4);

        // 4: one disabled cycle clears everything
        en = 1'b0;
        tick();
        en = 1'b1;
        for (int s = 0; s < 16; s++) rd_check($sformatf("dis_idx%0d", s), 4'(s), 32'd0);
        chk("dis_ovf", {31'd0, overflow}, 32'd0);

        // 5: 20 dcache request pulses saturate the 4-bit instance
        repeat (20) begin
            cyc(6'b001000, 1);
            cyc(6'b000000, 1);
        end
        rd_check("dreq_20", ABACUS_CACHE_DCACHE_REQ, 32'd20);
        chk("dreq_sat_n", {28'd0, rd_data_n}, 32'hF);
        chk("sat_ovf_n", {31'd0, overflow_n}, 32'd1);
        rd_check("status_w32", ABACUS_CACHE_STATUS, 32'd0);
        en = 1'b0;
        tick();
        en = 1'b1;
        rd_check("status_clr", ABACUS_CACHE_STATUS, 32'd0);
        chk("status_clr_n", {28'd0, rd_data_n}, 32'd0);
        chk("ovf_clr_n", {31'd0, overflow_n}, 32'd0);

        // 6: async reset mid-fill, release with fill still high
        cyc(6'b000100, 20);
        rd_check("icyc_pre", ABACUS_CACHE_ICACHE_FILL_CYC, 32'd20);
        chk("ovf_pre_n", {31'd0, overflow_n}, 32'd1);
        rst = 1'b0;
        #1;
        model_clear();
        prev = '0;
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_rd_n", {28'd0, rd_data_n}, 32'd0);
        chk("rst_ovf_n", {31'd0, overflow_n}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        cyc(6'b000100, 3);
        lv = 6'b000000;
        rd_check("icyc_post", ABACUS_CACHE_ICACHE_FILL_CYC, 32'd3);
        rd_check("imax_post", ABACUS_CACHE_ICACHE_FILL_MAX, MAX_EN ? 32'd3 : 32'd0);

        // random traffic: sticky-ish levels, occasional disables, random reads
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 3) == 0) lv[b] = ~lv[b];
            en     = ($urandom_range(0, 59) != 0);
            rd_sel = 4'($urandom_range(0, 15));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
